blackjack_round_ctrl: RTL

- Round sequencer for the card generator: issues single-cycle `on` requests, captures `card1_out`/`card2_out`, and deals two cards to the player and two to the dealer.
- Runs the player hit/stand phase, then the dealer draw-to-17 phase, and reports the outcome.
- Sits between the button/debounce logic and the card generator. Sum and outcome outputs feed the display block.

---
 rtl/blackjack_round_ctrl.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/blackjack_round_ctrl.sv
// blackjack_round_ctrl: one round of blackjack. It deals two cards to the
// player and two to the dealer, runs the player hit/stand phase and then the
// dealer draw phase, and reports sums and the outcome.
// Optional build macro: BJ_DEALER_HITS_SOFT17_EN (dealer also draws on soft 17).
//
// Generator handshake: card_on is a one-cycle request, high only in REQ.
// The generator has no ready signal. card1_in/card2_in are sampled exactly
// CARD_LAT cycles after the request cycle. A required card of 0 or >10 is a
// miss: the hand is left unchanged and the request is re-issued.
module blackjack_round_ctrl #(
  parameter int unsigned CARD_LAT     = 1,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned DEALER_STAND = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       hit,
  input  logic       stand,
  input  logic [3:0] card1_in,
  input  logic [3:0] card2_in,
  output logic       card_on,
  output logic [4:0] player_sum,
  output logic [4:0] dealer_sum,
  output logic       player_turn,
  output logic [2:0] outcome,
  output logic       round_done,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_REQ      = 4'd1,
    S_WAIT     = 4'd2,
    S_CHECK_BJ = 4'd3,
    S_PLAYER   = 4'd4,
    S_HIT_CHK  = 4'd5,
    S_DEALER   = 4'd6,
    S_COMPARE  = 4'd7,
    S_DONE     = 4'd8,
    S_ERROR    = 4'd9
  } state_t;

  // What the outstanding card request is for.
  typedef enum logic [1:0] {
    T_DEAL_P = 2'd0,
    T_DEAL_D = 2'd1,
    T_HIT    = 2'd2,
    T_DRAW   = 2'd3
  } tgt_t;

  state_t     state_q, state_d;
  tgt_t       tgt_q, tgt_d;
  logic [7:0] wait_q, wait_d;
  logic [3:0] retry_q, retry_d;
  logic [4:0] p_hard_q, p_hard_d, d_hard_q, d_hard_d;
  logic       p_ace_q, p_ace_d, d_ace_q, d_ace_d;
  logic [2:0] outcome_q, outcome_d;
  logic       done_q, done_d;

  logic [4:0] p_best, d_best;
  logic       d_soft, two_card, miss, d_draw;

  function automatic logic [4:0] sat_add(input logic [4:0] a, input logic [3:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {2'b00, b};
    return s[5] ? 5'd31 : s[4:0];
  endfunction

  function automatic logic bad_card(input logic [3:0] c);
    return (c == 4'd0) || (c > 4'd10);
  endfunction

  assign p_best   = (p_ace_q && p_hard_q <= 5'd11) ? p_hard_q + 5'd10 : p_hard_q;
  assign d_soft   = d_ace_q && d_hard_q <= 5'd11;
  assign d_best   = d_soft ? d_hard_q + 5'd10 : d_hard_q;
  assign two_card = (tgt_q == T_DEAL_P) || (tgt_q == T_DEAL_D);
  assign miss     = bad_card(card1_in) || (two_card && bad_card(card2_in));

`ifdef BJ_DEALER_HITS_SOFT17_EN
  assign d_draw = (d_best < 5'(DEALER_STAND)) || (d_soft && d_best == 5'(DEALER_STAND));
`else
  assign d_draw = d_best < 5'(DEALER_STAND);
`endif

  assign card_on     = (state_q == S_REQ);
  assign player_turn = (state_q == S_PLAYER);
  assign player_sum  = p_best;
  assign dealer_sum  = d_best;
  assign outcome     = outcome_q;
  assign round_done  = done_q;
  assign dbg_state   = state_q;

  // State and datapath registers; reset aborts any round in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tgt_q     <= T_DEAL_P;
      wait_q    <= '0;
      retry_q   <= '0;
      p_hard_q  <= '0;
      p_ace_q   <= 1'b0;
      d_hard_q  <= '0;
      d_ace_q   <= 1'b0;
      outcome_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      wait_q    <= wait_d;
      retry_q   <= retry_d;
      p_hard_q  <= p_hard_d;
      p_ace_q   <= p_ace_d;
      d_hard_q  <= d_hard_d;
      d_ace_q   <= d_ace_d;
      outcome_q <= outcome_d;
      done_q    <= done_d;
    end
  end

  // Next-state, card capture and outcome decisions.
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    wait_d    = wait_q;
    retry_d   = retry_q;
    p_hard_d  = p_hard_q;
    p_ace_d   = p_ace_q;
    d_hard_d  = d_hard_q;
    d_ace_d   = d_ace_q;
    outcome_d = outcome_q;
    done_d    = done_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d   = S_REQ;
          tgt_d     = T_DEAL_P;
          retry_d   = '0;
          p_hard_d  = '0;
          p_ace_d   = 1'b0;
          d_hard_d  = '0;
          d_ace_d   = 1'b0;
          outcome_d = '0;
          done_d    = 1'b0;
        end
      end
      S_REQ: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == 8'(CARD_LAT - 1)) begin
          if (miss) begin
            if (({1'b0, retry_q} + 5'd1) >= 5'(MAX_RETRY)) begin
              state_d   = S_ERROR;
              outcome_d = 3'd7;
              done_d    = 1'b1;
            end else begin
              retry_d = retry_q + 4'd1;
              state_d = S_REQ;
            end
          end else begin
            retry_d = '0;
            case (tgt_q)
              T_DEAL_P: begin
                p_hard_d = sat_add(sat_add(p_hard_q, card1_in), card2_in);
                p_ace_d  = p_ace_q || card1_in == 4'd1 || card2_in == 4'd1;
                tgt_d    = T_DEAL_D;
                state_d  = S_REQ;
              end
              T_DEAL_D: begin
                d_hard_d = sat_add(sat_add(d_hard_q, card1_in), card2_in);
                d_ace_d  = d_ace_q || card1_in == 4'd1 || card2_in == 4'd1;
                state_d  = S_CHECK_BJ;
              end
              T_HIT: begin
                p_hard_d = sat_add(p_hard_q, card1_in);
                p_ace_d  = p_ace_q || card1_in == 4'd1;
                state_d  = S_HIT_CHK;
              end
              default: begin
                d_hard_d = sat_add(d_hard_q, card1_in);
                d_ace_d  = d_ace_q || card1_in == 4'd1;
                state_d  = S_DEALER;
              end
            endcase
          end
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_CHECK_BJ: begin
        if (p_best == 5'd21) begin
          outcome_d = (d_best == 5'd21) ? 3'd3 : 3'd4;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d = S_PLAYER;
        end
      end
      S_PLAYER: begin
        if (hit) begin
          tgt_d   = T_HIT;
          state_d = S_REQ;
        end else if (stand) begin
          state_d = S_DEALER;
        end
      end
      S_HIT_CHK: begin
        if (p_best > 5'd21) begin
          outcome_d = 3'd2;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else if (p_best == 5'd21) begin
          state_d = S_DEALER;
        end else begin
          state_d = S_PLAYER;
        end
      end
      S_DEALER: begin
        if (d_draw) begin
          tgt_d   = T_DRAW;
          state_d = S_REQ;
        end else begin
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (d_best > 5'd21 || p_best > d_best) outcome_d = 3'd1;
        else if (p_best < d_best)              outcome_d = 3'd2;
        else                                   outcome_d = 3'd3;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
